// File: rtl/param_counter.sv
// Parametrised 74HC161-style synchronous counter: programmable width/modulus,
// up/down, ENP/ENT cascading with ripple carry, optional saturation, wrap pulse, sticky overflow.
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 2**WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] in,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             rco,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TC  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             term, cnt;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt, ovf_nxt;

  // ">=" in up mode so an out-of-range load still terminates on the next count
  assign term = up ? (out >= TC) : (out == '0);
  assign rco  = ent & term;
  assign cnt  = enp & ent;

  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf & ~ovf_clr;
    if (!sclr_n) begin
      out_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (!load_n) begin
      out_nxt = in;
      ovf_nxt = ovf;
    end else if (cnt) begin
      if (!term) begin
        out_nxt = up ? out + ONE : out - ONE;
      end else begin
        // terminal event beats a simultaneous ovf_clr
        ovf_nxt = 1'b1;
        if (!SATURATE) begin
          out_nxt  = up ? '0 : TC;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      out  <= out_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: stimulus queues expected post-edge values,
// a monitor pops and compares them one time step after each rising edge.
module tb_param_counter;

  localparam int ND = 5;  // 0: mod16 wrap, 1: mod10 wrap, 2: mod16 sat, 3/4: cascade lo/hi
  localparam int MODS [ND] = '{16, 10, 16, 16, 16};
  localparam bit SATS [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] clr_v, sclr_v, load_v, enp_v, ent_v, up_v, ovfc_v;
  logic [3:0]    in_v  [ND];
  logic [3:0]    out_v [ND];
  logic [ND-1:0] rco_v, wrap_v, ovf_v;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    param_counter #(.WIDTH(4), .MODULO(MODS[d]), .SATURATE(SATS[d])) u_dut (
      .clk(clk), .clr(clr_v[d]), .sclr_n(sclr_v[d]), .load_n(load_v[d]), .in(in_v[d]),
      .enp(enp_v[d]), .ent((d == 4) ? rco_v[3] : ent_v[d]), .up(up_v[d]), .ovf_clr(ovfc_v[d]),
      .out(out_v[d]), .rco(rco_v[d]), .wrap(wrap_v[d]), .ovf(ovf_v[d])
    );
  end

  typedef struct {
    int    cyc;
    int    d;
    int    s;
    int    exp;
    string name;
  } chk_t;

  chk_t q[$];
  int   cyc_now = 0;
  int   checks  = 0;
  int   errors  = 0;

  function automatic logic [31:0] actual(int d, int s);
    case (s)
      0:       return 32'(out_v[d]);
      1:       return 32'(wrap_v[d]);
      2:       return 32'(ovf_v[d]);
      3:       return 32'(rco_v[d]);
      default: return 32'({out_v[4], out_v[3]});
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    cyc_now++;
    while (q.size() > 0 && q[0].cyc <= cyc_now) begin
      chk_t        e;
      logic [31:0] act;
      e   = q.pop_front();
      act = actual(e.d, e.s);
      checks++;
      if (act !== 32'(e.exp)) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc_now);
      end
    end
  end

  // expectation for the state just after the coming rising edge
  task automatic chk(int d, int s, int exp, string nm);
    q.push_back('{cyc_now + 1, d, s, exp, nm});
  endtask

  task automatic chk4(int d, int o, int w, int ov, int r, string nm);
    chk(d, 0, o,  {nm, ".out"});
    chk(d, 1, w,  {nm, ".wrap"});
    chk(d, 2, ov, {nm, ".ovf"});
    chk(d, 3, r,  {nm, ".rco"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int seq [4];
    clr_v  = '1; sclr_v = '1; load_v = '1; enp_v = '0; ent_v = '0;
    up_v   = '1; ovfc_v = '0;
    for (int d = 0; d < ND; d++) in_v[d] = 4'd0;

    // reset state with count enabled while clr is held
    enp_v[0] = 1'b1; ent_v[0] = 1'b1;
    @(negedge clk);
    chk4(0, 0, 0, 0, 0, "reset");
    @(negedge clk);
    clr_v[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      chk4(0, i % 16, int'(i == 16), int'(i >= 16), int'((i % 16) == 15), $sformatf("upwrap%0d", i));
      @(negedge clk);
    end
    enp_v[0] = 1'b0;

    // modulo-10 load and count
    clr_v[1] = 1'b0; load_v[1] = 1'b0; in_v[1] = 4'd7;
    chk4(1, 7, 0, 0, 0, "ld7");
    @(negedge clk);
    load_v[1] = 1'b1; enp_v[1] = 1'b1; ent_v[1] = 1'b1;
    seq = '{8, 9, 0, 1};
    for (int k = 0; k < 4; k++) begin
      chk4(1, seq[k], int'(seq[k] == 0), int'(k >= 2), int'(seq[k] == 9), $sformatf("m10_%0d", k));
      @(negedge clk);
    end
    load_v[1] = 1'b0; in_v[1] = 4'd12;  // load wins over count
    chk4(1, 12, 0, 1, 1, "ld12");
    @(negedge clk);
    load_v[1] = 1'b1;
    chk4(1, 0, 1, 1, 0, "oor_wrap");
    @(negedge clk);
    load_v[1] = 1'b0; in_v[1] = 4'd1; up_v[1] = 1'b0;
    chk4(1, 1, 0, 1, 0, "ld1dn");
    @(negedge clk);
    load_v[1] = 1'b1;
    chk4(1, 0, 0, 1, 1, "dn0");
    @(negedge clk);
    chk4(1, 9, 1, 1, 0, "dnwrap");
    @(negedge clk);
    ovfc_v[1] = 1'b1;
    chk4(1, 8, 0, 0, 0, "ovfclr");
    @(negedge clk);
    ovfc_v[1] = 1'b0;
    for (int o = 7; o >= 0; o--) begin
      chk4(1, o, 0, 0, int'(o == 0), $sformatf("dn%0d", o));
      @(negedge clk);
    end
    ovfc_v[1] = 1'b1;
    chk4(1, 9, 1, 1, 0, "ovfclr_wrap");
    @(negedge clk);
    ovfc_v[1] = 1'b0; enp_v[1] = 1'b0; ent_v[1] = 1'b0;

    // saturating down count, enables and priority
    clr_v[2] = 1'b0; load_v[2] = 1'b0; in_v[2] = 4'd1; up_v[2] = 1'b0;
    enp_v[2] = 1'b1; ent_v[2] = 1'b1;
    chk4(2, 1, 0, 0, 0, "sld1");
    @(negedge clk);
    load_v[2] = 1'b1;
    chk4(2, 0, 0, 0, 1, "sdn0");
    @(negedge clk);
    chk4(2, 0, 0, 1, 1, "shold1");
    @(negedge clk);
    chk4(2, 0, 0, 1, 1, "shold2");
    @(negedge clk);
    load_v[2] = 1'b0; in_v[2] = 4'd15; up_v[2] = 1'b1;
    chk4(2, 15, 0, 1, 1, "sld15");
    @(negedge clk);
    load_v[2] = 1'b1; enp_v[2] = 1'b0;
    chk4(2, 15, 0, 1, 1, "enp0");
    @(negedge clk);
    enp_v[2] = 1'b1; ent_v[2] = 1'b0;
    chk4(2, 15, 0, 1, 0, "ent0");
    @(negedge clk);
    ent_v[2] = 1'b1;
    chk4(2, 15, 0, 1, 1, "satup");
    @(negedge clk);
    sclr_v[2] = 1'b0; load_v[2] = 1'b0; in_v[2] = 4'd9;
    chk4(2, 0, 0, 0, 0, "sclr");
    @(negedge clk);
    sclr_v[2] = 1'b1; load_v[2] = 1'b1; enp_v[2] = 1'b0; ent_v[2] = 1'b0;

    // async clear between edges: a short pulse must still clear, then the edge counts
    enp_v[0] = 1'b1;
    chk4(0, 5, 0, 1, 0, "pre5");
    @(negedge clk);
    clr_v[0] = 1'b1;
    #2 clr_v[0] = 1'b0;
    chk4(0, 1, 0, 0, 0, "clrpulse");
    @(negedge clk);
    clr_v[0] = 1'b1;
    chk4(0, 0, 0, 0, 0, "clrhold");
    @(negedge clk);
    clr_v[0] = 1'b0; enp_v[0] = 1'b0;

    // two-stage cascade
    clr_v[3] = 1'b0; clr_v[4] = 1'b0;
    enp_v[3] = 1'b1; enp_v[4] = 1'b1; ent_v[3] = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      chk(3, 4, i % 256, $sformatf("casc%0d", i));
      @(negedge clk);
    end
    enp_v[3] = 1'b0; enp_v[4] = 1'b0;

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
